// File: rtl/board_pkg.sv
// board_pkg: board-wide constants and debounce channel state encoding.
package board_pkg;
  localparam int BTN_COUNT = 5;
  localparam int CLK_HZ = 12_000_000;
  localparam int DEBOUNCE_CYCLES = 240000;
  // Encoded as {level, pending}; pending means the counter is non-zero.
  typedef enum logic [1:0] {
    LOW_STABLE   = 2'b00,
    LOW_PENDING  = 2'b01,
    HIGH_STABLE  = 2'b10,
    HIGH_PENDING = 2'b11
  } deb_state_t;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchronizer, stability counter, level, edge pulses and toggle for one button.
module debounce_channel
  import board_pkg::*;
#(
  parameter int STABLE_CYCLES = DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic toggle
);
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  logic s1, s2, accept;
  logic [CW-1:0] cnt, cnt_next;
  deb_state_t state, state_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      state  <= LOW_STABLE;
      rise   <= 1'b0;
      fall   <= 1'b0;
      toggle <= 1'b0;
    end else begin
      s1     <= sw;
      s2     <= s1;
      cnt    <= cnt_next;
      state  <= state_next;
      rise   <= accept & s2;
      fall   <= accept & ~s2;
      toggle <= toggle ^ (accept & s2);
    end
  end
  // Any sample matching the current level clears the count (glitch reject).
  always_comb begin
    accept     = (s2 != state[1]) && (cnt == LAST);
    cnt_next   = (s2 == state[1] || accept) ? '0 : cnt + 1'b1;
    state_next = deb_state_t'({state[1] ^ accept, cnt_next != '0});
  end
  assign level = state[1];
endmodule

// File: rtl/button_debounce.sv
// button_debounce: N independent debounced button channels feeding the LED stage.
module button_debounce
  import board_pkg::*;
#(
  parameter int N = BTN_COUNT,
  parameter int STABLE_CYCLES = DEBOUNCE_CYCLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_rise,
  output logic [N-1:0] btn_fall,
  output logic [N-1:0] btn_toggle
);
  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .sw    (sw[i]),
      .level (btn_level[i]),
      .rise  (btn_rise[i]),
      .fall  (btn_fall[i]),
      .toggle(btn_toggle[i])
    );
  end
endmodule
